au_req_arbiter: RTL and testbench

Sequencing arbiter that shares the single 4-bit arithmetic unit (AU) between two requesters. Accepts operand pairs over valid/ready handshakes, selects a winner, and drives the AU operand registers and the 2:1 operand-mux select. Captures the AU result and returns it with the winner's ID over a response handshake. Sits between the requester front-ends and the combinational AU datapath; one transaction in flight at a time.

---
 rtl/au_req_arbiter.sv | 154 +++++++++++++++
 tb/tb_au_req_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/au_req_arbiter.sv
// ---------------------------------------------------------------------------
// au_req_arbiter
//
// Purpose:
//   Shares the single 4-bit arithmetic unit (AU) between two requesters.
//   Operand pairs come in over valid/ready handshakes. The arbiter picks a
//   winner and loads the AU operand registers and the operand-mux select.
//   One cycle later it captures the AU result. It then returns that result,
//   tagged with the winner's ID, over a response handshake. Only one
//   transaction is in flight at a time (IDLE -> EXEC -> RESP).
//
// Configuration:
//   AU_ARB_FIXED_PRIO_EN  when defined, requester 0 always wins a tie.
//                         last_grant is still tracked but is ignored.
//                         When undefined (default), ties alternate
//                         round-robin against last_grant.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   req0_valid/a/b, req0_ready  requester 0 operand handshake
//   req1_valid/a/b, req1_ready  requester 1 operand handshake
//   mux_sel                   operand-mux select (0 = req0, 1 = req1)
//   au_a, au_b                registered AU operands
//   au_start                  one-cycle pulse while the AU evaluates
//   au_result, au_cout        AU combinational result / carry-borrow
//   rsp_valid/id/data/cout    response to the consumer
//   rsp_ready                 consumer accepts the response
//   busy                      high in any state except IDLE
// ---------------------------------------------------------------------------
module au_req_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic             mux_sel,
   output logic [WIDTH-1:0] au_a,
   output logic [WIDTH-1:0] au_b,
   output logic             au_start,
   input  logic [WIDTH-1:0] au_result,
   input  logic             au_cout,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_cout,
   input  logic             rsp_ready,
   output logic             busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0] state_r;
   logic       last_grant_r;
   logic       grant_s;
   logic       accept_s;

   // Grant selection: a single valid wins outright; a tie goes to the
   // requester that did not win last time (or to req0 with fixed priority).
   always_comb begin
      grant_s = 1'b0;
      if (req0_valid && req1_valid) begin
`ifdef AU_ARB_FIXED_PRIO_EN
         grant_s = 1'b0;
`else
         grant_s = ~last_grant_r;
`endif
      end else if (req1_valid) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end

   // Handshake decode: readies exist only in IDLE, outside reset, and only
   // towards the granted requester, so a valid & ready pair is an accept.
   always_comb begin
      accept_s   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if ((state_r == ST_IDLE) && !rst) begin
         accept_s   = req0_valid || req1_valid;
         req0_ready = req0_valid && !grant_s;
         req1_ready = req1_valid &&  grant_s;
      end else begin
         accept_s   = 1'b0;
      end
   end

   // Sequencer state plus all registered outputs. The AU operands and
   // mux_sel stay put after EXEC so the datapath remains stable until the
   // next accept overwrites them.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         last_grant_r <= 1'b1;
         mux_sel      <= 1'b0;
         au_a         <= {WIDTH{1'b0}};
         au_b         <= {WIDTH{1'b0}};
         au_start     <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_data     <= {WIDTH{1'b0}};
         rsp_cout     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  au_a         <= grant_s ? req1_a : req0_a;
                  au_b         <= grant_s ? req1_b : req0_b;
                  mux_sel      <= grant_s;
                  rsp_id       <= grant_s;
                  last_grant_r <= grant_s;
                  au_start     <= 1'b1;
                  busy         <= 1'b1;
                  state_r      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               // The AU output is sampled at the end of the start cycle.
               // Later changes on au_result do not reach the response.
               au_start  <= 1'b0;
               rsp_data  <= au_result;
               rsp_cout  <= au_cout;
               rsp_valid <= 1'b1;
               state_r   <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state_r   <= ST_IDLE;
               end
            end
            default: begin
               au_start  <= 1'b0;
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_au_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_au_req_arbiter
//
// Directed bench for au_req_arbiter. The bench stands in for the AU as an
// adder, with an override that can force au_result to 9. Each expected
// response is pushed to a scoreboard queue before its stimulus. A separate
// monitor pops and compares an entry on every completed response handshake.
// Inline checks cover reset values, handshake timing and stability.
// ---------------------------------------------------------------------------
module tb_au_req_arbiter;

   typedef struct packed {
      logic       id;
      logic [3:0] data;
      logic       cout;
   } rsp_t;

   logic       clk;
   logic       rst;
   logic       req0_valid, req1_valid;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic       req0_ready, req1_ready;
   logic       mux_sel;
   logic [3:0] au_a, au_b;
   logic       au_start;
   logic [3:0] au_result;
   logic       au_cout;
   logic       rsp_valid, rsp_id, rsp_cout, rsp_ready;
   logic [3:0] rsp_data;
   logic       busy;
   logic       force9;
   logic [4:0] sum;

   int   checks;
   int   failures;
   rsp_t sb[$];
   rsp_t mon_exp;

   au_req_arbiter #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .mux_sel(mux_sel), .au_a(au_a), .au_b(au_b), .au_start(au_start),
      .au_result(au_result), .au_cout(au_cout),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_cout(rsp_cout),
      .rsp_ready(rsp_ready), .busy(busy)
   );

   // AU stand-in: 4-bit adder with carry, optionally forced to 9.
   assign sum       = {1'b0, au_a} + {1'b0, au_b};
   assign au_result = force9 ? 4'd9 : sum[3:0];
   assign au_cout   = force9 ? 1'b0 : sum[4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic id, input logic [3:0] data, input logic cout);
      rsp_t e;
      e.id = id; e.data = data; e.cout = cout;
      sb.push_back(e);
   endtask

   // Monitor: every completed response handshake must match the oldest
   // expected entry; a response with nothing expected is itself a failure.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp actual id=%0d data=%0h expected=none @%0t",
                     rsp_id, rsp_data, $time);
         end else begin
            mon_exp = sb.pop_front();
            chk("sb_rsp_id",   {31'd0, rsp_id},   {31'd0, mon_exp.id});
            chk("sb_rsp_data", {28'd0, rsp_data}, {28'd0, mon_exp.data});
            chk("sb_rsp_cout", {31'd0, rsp_cout}, {31'd0, mon_exp.cout});
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; force9 = 1'b0; rsp_ready = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = 4'd0; req0_b = 4'd0; req1_a = 4'd0; req1_b = 4'd0;
      tick(); tick();

      // Reset state; readies stay low in reset even with a valid present.
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
      chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
      chk("rst_mux_sel",    {31'd0, mux_sel},    32'd0);
      chk("rst_au_a",       {28'd0, au_a},       32'd0);
      chk("rst_au_b",       {28'd0, au_b},       32'd0);
      chk("rst_au_start",   {31'd0, au_start},   32'd0);
      chk("rst_rsp_valid",  {31'd0, rsp_valid},  32'd0);
      chk("rst_rsp_id",     {31'd0, rsp_id},     32'd0);
      chk("rst_rsp_data",   {28'd0, rsp_data},   32'd0);
      chk("rst_rsp_cout",   {31'd0, rsp_cout},   32'd0);
      chk("rst_busy",       {31'd0, busy},       32'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst = 1'b0;
      tick();

      // Single request: req0 3+5 = 8.
      req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
      push(1'b0, 4'd8, 1'b0);
      #1;
      chk("single_req0_ready", {31'd0, req0_ready}, 32'd1);
      chk("single_req1_ready", {31'd0, req1_ready}, 32'd0);
      tick();
      req0_valid = 1'b0;
      chk("single_au_start",  {31'd0, au_start},  32'd1);
      chk("single_mux_sel",   {31'd0, mux_sel},   32'd0);
      chk("single_au_a",      {28'd0, au_a},      32'd3);
      chk("single_au_b",      {28'd0, au_b},      32'd5);
      chk("single_busy",      {31'd0, busy},      32'd1);
      chk("single_rsp_valid_exec", {31'd0, rsp_valid}, 32'd0);
      rsp_ready = 1'b1;
      tick();
      chk("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("single_rsp_id",    {31'd0, rsp_id},    32'd0);
      chk("single_rsp_data",  {28'd0, rsp_data},  32'd8);
      chk("single_au_start_low", {31'd0, au_start}, 32'd0);
      tick();
      chk("single_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("single_idle_busy",      {31'd0, busy},      32'd0);
      chk("single_hold_au_a",      {28'd0, au_a},      32'd3);

      // Contention after reset: req0 1+2=3, req1 7+9=16 (0, carry).
      rst = 1'b1; tick(); rst = 1'b0;
`ifdef AU_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) push(1'b0, 4'd3, 1'b0);
`else
      for (int i = 0; i < 2; i++) begin
         push(1'b0, 4'd3, 1'b0);
         push(1'b1, 4'd0, 1'b1);
      end
`endif
      req0_a = 4'd1; req0_b = 4'd2; req1_a = 4'd7; req1_b = 4'd9;
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      chk("contention_drained", sb.size(), 32'd0);

      // Backpressure: req0 4+4=8 held in RESP while rsp_ready is low.
      rsp_ready = 1'b0;
      push(1'b0, 4'd8, 1'b0);
      req0_a = 4'd4; req0_b = 4'd4; req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      tick();
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("bp_rsp_valid",  {31'd0, rsp_valid},  32'd1);
         chk("bp_rsp_data",   {28'd0, rsp_data},   32'd8);
         chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
         chk("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
         chk("bp_busy",       {31'd0, busy},       32'd1);
         if (i == 5) begin
            req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
         end
         tick();
      end
      chk("bp_released", {31'd0, rsp_valid}, 32'd0);

      // Capture timing: req1 2+3=5, AU output forced to 9 during RESP.
      rsp_ready = 1'b0;
      push(1'b1, 4'd5, 1'b0);
      req1_a = 4'd2; req1_b = 4'd3; req1_valid = 1'b1;
      tick();
      req1_valid = 1'b0;
      chk("cap_mux_sel", {31'd0, mux_sel}, 32'd1);
      tick();
      force9 = 1'b1;
      #1;
      chk("cap_rsp_data_0", {28'd0, rsp_data}, 32'd5);
      tick();
      chk("cap_rsp_data_1", {28'd0, rsp_data}, 32'd5);
      rsp_ready = 1'b1;
      tick();
      force9 = 1'b0;

      // Reset in EXEC: req0 transaction dropped, then tie goes to req0.
      req0_a = 4'd6; req0_b = 4'd6; req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      chk("rexec_au_start", {31'd0, au_start}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rexec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rexec_busy",      {31'd0, busy},      32'd0);
      chk("rexec_mux_sel",   {31'd0, mux_sel},   32'd0);
      chk("rexec_au_a",      {28'd0, au_a},      32'd0);
      push(1'b0, 4'd10, 1'b0);
      req0_a = 4'd5; req0_b = 4'd5; req1_a = 4'd1; req1_b = 4'd1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("rexec_tie_req0_ready", {31'd0, req0_ready}, 32'd1);
      chk("rexec_tie_req1_ready", {31'd0, req1_ready}, 32'd0);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick(); tick();

      // Valid withdrawn: req1 pulses once during RESP, is never accepted.
      rsp_ready = 1'b0;
      push(1'b0, 4'd0, 1'b1);
      req0_a = 4'd15; req0_b = 4'd1; req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      tick();
      req1_valid = 1'b1;
      #1;
      chk("wd_req1_ready", {31'd0, req1_ready}, 32'd0);
      tick();
      req1_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("wd_idle_busy", {31'd0, busy}, 32'd0);
      chk("final_sb_empty", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
